cfg_bit_loader: RTL

Configuration loader that sits directly upstream of the grid tiles' configuration port. Accepts a byte stream on a valid/ready handshake, parses a framed header, and serializes the payload into one-bit writes on `enable`/`address`/`data_in`, the configuration-write triple consumed by `grid_clb`. The block handles framing, address sequencing, bounds checking and completion/error reporting, so downstream tiles see only clean single-bit writes.

---
 rtl/cfg_bit_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cfg_bit_loader.sv
// Byte-stream configuration loader: parses an A5-framed header and emits
// one-bit enable/address/data_in writes for the grid tiles' configuration port.
module cfg_bit_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic                  data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Header byte2 supplies address bits [ADDR_WIDTH-1:8]; ADDR_WIDTH must be 9..16.
  localparam logic [16:0] SPACE = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, HDR, LOAD, SHIFT, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              hdr_cnt_q, hdr_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             count_q, count_d;
  logic [3:0]              bits_q, bits_d;
  logic [7:0]              shift_q, shift_d;

  logic                    s_ready_q, s_ready_d;
  logic                    enable_q, enable_d;
  logic [0:ADDR_WIDTH-1]   address_q, address_d;
  logic                    data_in_q, data_in_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic [15:0]             hdr_count;
  logic [16:0]             hdr_end;

  always_comb begin
    accept    = s_valid && s_ready_q;
    hdr_count = {s_data, count_q[7:0]};
    hdr_end   = {{(17-ADDR_WIDTH){1'b0}}, addr_q} + {1'b0, hdr_count};

    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    addr_d    = addr_q;
    count_d   = count_q;
    bits_d    = bits_q;
    shift_d   = shift_q;
    error_d   = error_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_data == 8'hA5) begin
            error_d   = 1'b0;
            hdr_cnt_d = 2'd0;
            state_d   = HDR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (accept) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd0: addr_d[7:0] = s_data;
            2'd1: addr_d[ADDR_WIDTH-1:8] = s_data[ADDR_WIDTH-9:0];
            2'd2: count_d[7:0] = s_data;
            2'd3: begin
              count_d = hdr_count;
              // 17-bit sum so an overflowing frame is caught before any write
              if (hdr_end > SPACE) begin
                error_d = 1'b1;
                state_d = DRAIN;
              end else if (hdr_count == 16'd0) begin
                state_d = DONE;
              end else begin
                state_d = LOAD;
              end
            end
          endcase
        end
      end
      LOAD: begin
        if (accept) begin
          shift_d = s_data;
          bits_d  = (count_q >= 16'd8) ? 4'd8 : count_q[3:0];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = {1'b0, shift_q[7:1]};
        addr_d  = addr_q + 1'b1;
        count_d = count_q - 16'd1;
        bits_d  = bits_q - 4'd1;
        if (bits_q == 4'd1) begin
          state_d = (count_q == 16'd1) ? DONE : LOAD;
        end
      end
      DRAIN: begin
        if (accept) begin
          if (count_q <= 16'd8) begin
            state_d = DONE;
          end else begin
            count_d = count_q - 16'd8;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Gating on DONE keeps s_ready low for the cycle that shows the done pulse
    s_ready_d = (state_d inside {IDLE, HDR, LOAD, DRAIN}) && (state_q != DONE);
    enable_d  = (state_q == SHIFT);
    address_d = enable_d ? addr_q : '0;
    data_in_d = enable_d & shift_q[0];
    busy_d    = (state_q != IDLE);
    done_d    = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      hdr_cnt_q <= 2'd0;
      addr_q    <= '0;
      count_q   <= 16'd0;
      bits_q    <= 4'd0;
      shift_q   <= 8'd0;
      s_ready_q <= 1'b0;
      enable_q  <= 1'b0;
      address_q <= '0;
      data_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      s_ready_q <= s_ready_d;
      enable_q  <= enable_d;
      address_q <= address_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign s_ready = s_ready_q;
  assign enable  = enable_q;
  assign address = address_q;
  assign data_in = data_in_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule
